// File: rtl/morse_sequencer.sv
// Morse playback engine: buffers packed Morse words in a small FIFO and
// replays them as timed short/long tone strobes with hardware spacing.
module morse_sequencer #(
    parameter int unsigned SYMBOLS      = 5,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned UNIT_CYCLES  = 12500000,
    parameter int unsigned DOT_UNITS    = 1,
    parameter int unsigned DASH_UNITS   = 3,
    parameter int unsigned GAP_UNITS    = 1,
    parameter int unsigned LETTER_UNITS = 3,
    parameter int unsigned WORD_UNITS   = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [2*SYMBOLS-1:0] morse,
    input  logic                 abort,
    output logic                 short,
    output logic                 long,
    output logic                 audio_enable,
    output logic                 busy,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow
);

    localparam int unsigned W   = 2 * SYMBOLS;
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned IW  = $clog2(SYMBOLS + 1);
    localparam int unsigned M1  = (DOT_UNITS > DASH_UNITS) ? DOT_UNITS : DASH_UNITS;
    localparam int unsigned M2  = (GAP_UNITS > LETTER_UNITS) ? GAP_UNITS : LETTER_UNITS;
    localparam int unsigned M3  = (M1 > M2) ? M1 : M2;
    localparam int unsigned MAXN = (M3 > WORD_UNITS) ? M3 : WORD_UNITS;
    localparam int unsigned CW  = $clog2(MAXN * UNIT_CYCLES + 1);

    localparam logic [CW-1:0] DOT_LD    = CW'(DOT_UNITS * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_LD   = CW'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD    = CW'(GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] LETTER_LD = CW'(LETTER_UNITS * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] WORD_LD   = CW'(WORD_UNITS * UNIT_CYCLES - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(SYMBOLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        TONE,
        GAP,
        LGAP,
        WGAP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          audio_q, audio_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];

    logic          pop;
    logic          push;
    logic          done;
    logic [W-1:0]  head;
    logic [W-1:0]  sh_nxt;

    function automatic logic code_ok(input logic [1:0] c);
        return (c == 2'b01) || (c == 2'b10);
    endfunction

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign head   = mem_q[rd_ptr_q];
    assign sh_nxt = sh_q >> 2;
    assign done   = (cnt_q == '0);

    // A full FIFO still accepts a load when a pop frees a slot that cycle.
    assign pop  = (state_q == IDLE) && !empty && !abort;
    assign push = load && !abort && (!full || pop);

    always_comb begin
        ovf_d    = load && !abort && full && !pop;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
        if (abort) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        short_d = short_q;
        long_d  = long_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    sh_d  = head;
                    idx_d = '0;
                    if (code_ok(head[1:0])) begin
                        state_d = TONE;
                        cnt_d   = (head[1:0] == 2'b01) ? DOT_LD : DASH_LD;
                        short_d = (head[1:0] == 2'b01);
                        long_d  = (head[1:0] == 2'b10);
                    end else begin
                        state_d = WGAP;
                        cnt_d   = WORD_LD;
                    end
                end
            end
            TONE: begin
                if (done) begin
                    sh_d    = sh_nxt;
                    idx_d   = idx_q + IW'(1);
                    short_d = 1'b0;
                    long_d  = 1'b0;
                    if (idx_q < LAST_IDX && code_ok(sh_nxt[1:0])) begin
                        state_d = GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = LGAP;
                        cnt_d   = LETTER_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (done) begin
                    state_d = TONE;
                    cnt_d   = (sh_q[1:0] == 2'b01) ? DOT_LD : DASH_LD;
                    short_d = (sh_q[1:0] == 2'b01);
                    long_d  = (sh_q[1:0] == 2'b10);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            LGAP, WGAP: begin
                if (done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                short_d = 1'b0;
                long_d  = 1'b0;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            sh_d    = '0;
            idx_d   = '0;
            short_d = 1'b0;
            long_d  = 1'b0;
        end
        audio_d = short_d | long_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            idx_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            audio_q  <= 1'b0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            idx_q    <= idx_d;
            short_q  <= short_d;
            long_q   <= long_d;
            audio_q  <= audio_d;
            ovf_q    <= ovf_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= morse;
        end
    end

    assign short        = short_q;
    assign long         = long_q;
    assign audio_enable = audio_q;
    assign busy         = (state_q != IDLE);
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer with UNIT_CYCLES=4.
// Each scenario task drives stimulus and checks its own results.
module tb_morse_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] morse = '0;
    logic       short, long, audio_enable, busy, full, empty, overflow;

    int errors = 0;
    int checks = 0;
    logic [2:0] exp_q[$];

    morse_sequencer #(.UNIT_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .morse(morse),
        .abort(abort),
        .short(short),
        .long(long),
        .audio_enable(audio_enable),
        .busy(busy),
        .full(full),
        .empty(empty),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Expected {short,long,busy} per cycle, n copies.
    task automatic seg(input logic [2:0] v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({short, long, audio_enable, busy, full, overflow, empty} !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_held: s l ae b f o e=%b%b%b%b%b%b%b want 0000001",
                     short, long, audio_enable, busy, full, overflow, empty);
        end
        reset = 1'b1;
        step;
        checks++;
        if ({short, long, audio_enable, busy, full, overflow, empty} !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_release: s l ae b f o e=%b%b%b%b%b%b%b want 0000001",
                     short, long, audio_enable, busy, full, overflow, empty);
        end
    endtask

    task automatic test_letter_a;
        exp_q.delete();
        seg(3'b101, 4);
        seg(3'b001, 4);
        seg(3'b011, 12);
        seg(3'b001, 12);
        seg(3'b000, 1);
        load = 1'b1;
        morse = 10'h009;
        step;
        load = 1'b0;
        step;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if ({short, long, busy} !== exp_q[i] ||
                audio_enable !== (exp_q[i][2] | exp_q[i][1])) begin
                errors++;
                $display("FAIL letter_a c%0d: s l b ae=%b%b%b%b want slb=%b",
                         i, short, long, busy, audio_enable, exp_q[i]);
            end
            step;
        end
    endtask

    task automatic test_five_dots;
        exp_q.delete();
        repeat (4) begin
            seg(3'b101, 4);
            seg(3'b001, 4);
        end
        seg(3'b101, 4);
        seg(3'b001, 12);
        seg(3'b000, 1);
        load = 1'b1;
        morse = 10'h155;
        step;
        load = 1'b0;
        step;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if ({short, long, busy} !== exp_q[i] ||
                audio_enable !== (exp_q[i][2] | exp_q[i][1])) begin
                errors++;
                $display("FAIL five_dots c%0d: s l b ae=%b%b%b%b want slb=%b",
                         i, short, long, busy, audio_enable, exp_q[i]);
            end
            step;
        end
    endtask

    task automatic test_word_space;
        exp_q.delete();
        seg(3'b001, 28);
        seg(3'b000, 1);
        seg(3'b101, 4);
        seg(3'b001, 12);
        seg(3'b000, 1);
        load = 1'b1;
        morse = 10'h000;
        step;
        morse = 10'h001;
        step;
        load = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if ({short, long, busy} !== exp_q[i] ||
                audio_enable !== (exp_q[i][2] | exp_q[i][1])) begin
                errors++;
                $display("FAIL word_space c%0d: s l b ae=%b%b%b%b want slb=%b",
                         i, short, long, busy, audio_enable, exp_q[i]);
            end
            step;
        end
    endtask

    task automatic test_overflow;
        int  rises;
        bit  prev;
        bit  saw_long;
        bit  found;
        load = 1'b1;
        morse = 10'h2AA;
        step;
        morse = 10'h001;
        repeat (3) step;
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL ovf_three_queued: full=%b want 0", full);
        end
        step;
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full: full=%b ovf=%b want 1 0", full, overflow);
        end
        morse = 10'h002;
        step;
        load = 1'b0;
        checks++;
        if (overflow !== 1'b1 || full !== 1'b1 || long !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pulse: ovf=%b full=%b long=%b want 1 1 1",
                     overflow, full, long);
        end
        step;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_one_cycle: ovf=%b want 0", overflow);
        end
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step;
            if (!busy) found = 1'b1;
        end
        checks++;
        if (!found || full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_stall_end: idle_seen=%b full=%b want 1 1", found, full);
        end
        load = 1'b1;
        morse = 10'h001;
        step;
        load = 1'b0;
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0 || short !== 1'b1) begin
            errors++;
            $display("FAIL ovf_push_pop: full=%b ovf=%b short=%b want 1 0 1",
                     full, overflow, short);
        end
        rises = 0;
        prev = 1'b1;
        saw_long = 1'b0;
        repeat (120) begin
            step;
            if (short && !prev) rises++;
            if (long) saw_long = 1'b1;
            prev = short;
        end
        checks++;
        if (rises !== 4 || saw_long !== 1'b0) begin
            errors++;
            $display("FAIL ovf_playback: extra_dots=%0d long_seen=%b want 4 0",
                     rises, saw_long);
        end
        checks++;
        if (empty !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drained: empty=%b busy=%b want 1 0", empty, busy);
        end
    endtask

    task automatic test_abort;
        bit noise;
        load = 1'b1;
        morse = 10'h2AA;
        step;
        morse = 10'h001;
        repeat (3) step;
        load = 1'b0;
        repeat (2) step;
        checks++;
        if (long !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre: long=%b empty=%b want 1 0", long, empty);
        end
        abort = 1'b1;
        load = 1'b1;
        morse = 10'h001;
        step;
        abort = 1'b0;
        load = 1'b0;
        checks++;
        if ({short, long, audio_enable, busy, full, overflow, empty} !== 7'b0000001) begin
            errors++;
            $display("FAIL abort_flush: s l ae b f o e=%b%b%b%b%b%b%b want 0000001",
                     short, long, audio_enable, busy, full, overflow, empty);
        end
        noise = 1'b0;
        repeat (60) begin
            step;
            if (audio_enable || busy || !empty) noise = 1'b1;
        end
        checks++;
        if (noise !== 1'b0) begin
            errors++;
            $display("FAIL abort_silent: activity=%b want 0", noise);
        end
    endtask

    task automatic test_async_reset;
        bit noise;
        load = 1'b1;
        morse = 10'h001;
        step;
        morse = 10'h002;
        step;
        load = 1'b0;
        checks++;
        if (short !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_tone: short=%b want 1", short);
        end
        repeat (7) step;
        checks++;
        if (busy !== 1'b1 || short !== 1'b0 || empty !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_lgap: busy=%b short=%b empty=%b want 1 0 0",
                     busy, short, empty);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({short, long, audio_enable, busy, full, overflow, empty} !== 7'b0000001) begin
            errors++;
            $display("FAIL rst_async: s l ae b f o e=%b%b%b%b%b%b%b want 0000001",
                     short, long, audio_enable, busy, full, overflow, empty);
        end
        step;
        step;
        reset = 1'b1;
        noise = 1'b0;
        repeat (40) begin
            step;
            if (audio_enable || busy || !empty) noise = 1'b1;
        end
        checks++;
        if (noise !== 1'b0) begin
            errors++;
            $display("FAIL rst_flushed: activity=%b want 0", noise);
        end
        load = 1'b1;
        morse = 10'h001;
        step;
        load = 1'b0;
        step;
        checks++;
        if (short !== 1'b1 || busy !== 1'b1 || long !== 1'b0) begin
            errors++;
            $display("FAIL rst_resume: short=%b busy=%b long=%b want 1 1 0",
                     short, busy, long);
        end
        repeat (20) step;
        checks++;
        if (busy !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL rst_resume_end: busy=%b empty=%b want 0 1", busy, empty);
        end
    endtask

    initial begin
        test_reset;
        test_letter_a;
        test_five_dots;
        test_word_space;
        test_overflow;
        test_abort;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
